instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 131 +++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes LDUR/STUR/CBZ requests into 32-bit words and
// queues them in a 4-entry FIFO; out-of-range or illegal requests are
// rejected with a one-cycle rej pulse and a saturating reject counter.
//
// Ports:
//   clk, reset               clock, async active-high reset
//   in_valid/in_ready        request handshake (in_ready = level < 4)
//   in_op, in_rt, in_rn      opcode (0 LDUR, 1 STUR, 2 CBZ, 3 illegal), regs
//   in_imm                   signed 64-bit immediate
//   out_valid/out_ready      FIFO head handshake
//   out_instr                FIFO head word (0 when empty)
//   rej, rej_count           reject pulse and saturating reject count
//   level                    FIFO occupancy 0..4
module instr_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rn,
   input  logic [63:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        rej,
   output logic [7:0]  rej_count,
   output logic [2:0]  level
);

   localparam logic [1:0] OP_LDUR = 2'd0;
   localparam logic [1:0] OP_STUR = 2'd1;
   localparam logic [1:0] OP_CBZ  = 2'd2;

   logic [31:0] r_mem [4];
   logic [1:0]  r_wptr;
   logic [1:0]  r_rptr;
   logic [2:0]  r_level;
   logic        r_rej;
   logic [7:0]  r_rej_cnt;

   logic        w_acc;
   logic        w_pop;
   logic        w_push;
   logic        w_rej_acc;
   logic        w_imm9_ok;
   logic        w_imm19_ok;
   logic        w_legal;
   logic [31:0] w_enc;

   assign w_acc = in_valid & in_ready;
   assign w_pop = out_valid & out_ready;

   // In range when every bit above the field's sign bit matches it.
   assign w_imm9_ok  = (in_imm[63:8]  == {56{in_imm[8]}});
   assign w_imm19_ok = (in_imm[63:18] == {46{in_imm[18]}});

   always_comb begin
      w_legal = 1'b0;
      w_enc   = 32'h0;
      unique case (in_op)
         OP_LDUR: begin
            w_legal = w_imm9_ok;
            w_enc   = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rt};
         end
         OP_STUR: begin
            w_legal = w_imm9_ok;
            w_enc   = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rt};
         end
         OP_CBZ: begin
            w_legal = w_imm19_ok;
            w_enc   = {8'b10110100, in_imm[18:0], in_rt};
         end
         default: begin
            w_legal = 1'b0;
            w_enc   = 32'h0;
         end
      endcase
   end

   assign w_push    = w_acc & w_legal;
   assign w_rej_acc = w_acc & ~w_legal;

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_enc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= 2'd0;
         r_rptr  <= 2'd0;
         r_level <= 3'd0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 2'd1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 2'd1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 3'd1;
            2'b01:   r_level <= r_level - 3'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rej     <= 1'b0;
         r_rej_cnt <= 8'd0;
      end else begin
         r_rej <= w_rej_acc;
         if (w_rej_acc && (r_rej_cnt != 8'hFF)) begin
            r_rej_cnt <= r_rej_cnt + 8'd1;
         end
      end
   end

   // Gated by reset so the input side is closed while reset is held.
   assign in_ready  = ~reset & (r_level < 3'd4);
   assign out_valid = (r_level != 3'd0);
   assign out_instr = out_valid ? r_mem[r_rptr] : 32'h0;
   assign rej       = r_rej;
   assign rej_count = r_rej_cnt;
   assign level     = r_level;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with directed
// boundary cases and randomized requests against a reference model.
module tb_instr_encoder;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [4:0]  in_rt;
   logic [4:0]  in_rn;
   logic [63:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        rej;
   logic [7:0]  rej_count;
   logic [2:0]  level;

   instr_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rt     (in_rt),
      .in_rn     (in_rn),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .rej       (rej),
      .rej_count (rej_count),
      .level     (level)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   int          ref_cnt = 0;
   bit          rnd_rdy = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: range by signed comparison, word built by arithmetic.
   function automatic void ref_enc(input logic [1:0] op,
                                   input logic [4:0] rt,
                                   input logic [4:0] rn,
                                   input logic [63:0] imm,
                                   output bit legal,
                                   output logic [31:0] w);
      longint s;
      s = imm;
      legal = 0;
      w = 32'h0;
      case (op)
         2'd0: begin
            legal = (s >= -256) && (s <= 255);
            w = 32'hF8400000 | (32'(imm & 64'h1FF) << 12)
                | (32'(rn) << 5) | 32'(rt);
         end
         2'd1: begin
            legal = (s >= -256) && (s <= 255);
            w = 32'hF8000000 | (32'(imm & 64'h1FF) << 12)
                | (32'(rn) << 5) | 32'(rt);
         end
         2'd2: begin
            legal = (s >= -262144) && (s <= 262143);
            w = 32'hB4000000 | (32'(imm & 64'h7FFFF) << 5) | 32'(rt);
         end
         default: legal = 0;
      endcase
   endfunction

   // Called at an idle point between edges; returns at posedge+1.
   task automatic send(input logic [1:0] op, input logic [4:0] rt,
                       input logic [4:0] rn, input logic [63:0] imm);
      bit          acc;
      bit          legal;
      logic [31:0] w;
      acc = 0;
      in_valid = 1;
      in_op = op;
      in_rt = rt;
      in_rn = rn;
      in_imm = imm;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) acc = 1;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      in_valid = 0;
      if (!acc) begin
         chk("accept_timeout", 0, 1);
         return;
      end
      ref_enc(op, rt, rn, imm, legal, w);
      if (legal) q.push_back(w);
      else if (ref_cnt != 255) ref_cnt++;
      chk("rej", rej, !legal);
      chk("rej_count", rej_count, ref_cnt);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         chk("rej_idle", rej, 0);
      end
   endtask

   // Monitor: level/valid vs model, head compared on every pop.
   initial begin
      forever begin
         @(negedge clk);
         chk("level", level, q.size());
         chk("out_valid", out_valid, q.size() != 0);
         if (q.size() == 0) chk("out_instr_empty", out_instr, 0);
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("pop_underflow", 1, 0);
            else chk("out_instr", out_instr, q.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   function automatic logic [63:0] pick_imm(input logic [1:0] op);
      logic [63:0] v;
      int          k;
      k = $urandom_range(0, 9);
      v = {$urandom, $urandom};
      if (op == 2'd2) begin
         case (k)
            0: v = -64'sd262145;
            1: v = -64'sd262144;
            2: v = 64'sd262143;
            3: v = 64'sd262144;
            4: v = v;
            default: v = 64'($urandom_range(0, 600000)) - 64'd300000;
         endcase
      end else begin
         case (k)
            0: v = -64'sd257;
            1: v = -64'sd256;
            2: v = 64'sd255;
            3: v = 64'sd256;
            4: v = v;
            default: v = 64'($urandom_range(0, 700)) - 64'd350;
         endcase
      end
      return v;
   endfunction

   initial begin
      logic [1:0] op;
      reset = 1;
      in_valid = 0;
      in_op = 0;
      in_rt = 0;
      in_rn = 0;
      in_imm = 0;
      out_ready = 0;
      #1;
      chk("rst_level", level, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_rej", rej, 0);
      chk("rst_rej_count", rej_count, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      out_ready = 1;
      send(2'd0, 5'd2, 5'd1, 64'sd1);
      send(2'd1, 5'd2, 5'd1, -64'sd2);
      send(2'd2, 5'd2, 5'd0, 64'sd3);
      send(2'd2, 5'd2, 5'd0, -64'sd3);
      idle(3);

      send(2'd0, 5'd5, 5'd6, 64'sd255);
      send(2'd0, 5'd5, 5'd6, -64'sd256);
      send(2'd0, 5'd5, 5'd6, 64'sd256);
      send(2'd2, 5'd5, 5'd0, 64'sd262144);
      idle(3);

      out_ready = 0;
      for (int i = 0; i < 4; i++) send(2'd1, 5'(i), 5'(i + 8), 64'(i * 7));
      chk("full_level", level, 4);
      chk("full_in_ready", in_ready, 0);
      fork
         send(2'd2, 5'd9, 5'd0, 64'sd100);
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1;
         end
      join
      idle(6);

      send(2'd3, 5'd1, 5'd1, 64'd0);
      for (int i = 0; i < 300; i++) send(2'd3, 5'd0, 5'd0, 64'(i));
      chk("rej_sat", rej_count, 255);
      idle(2);

      out_ready = 0;
      for (int i = 0; i < 3; i++) send(2'd0, 5'(i), 5'd3, 64'(i));
      idle(1);
      #2;
      reset = 1;
      #1;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_instr", out_instr, 0);
      chk("mid_rst_rej_count", rej_count, 0);
      q.delete();
      ref_cnt = 0;
      @(negedge clk);
      #2;
      reset = 0;
      #1;
      chk("rel_in_ready", in_ready, 1);
      send(2'd0, 5'd2, 5'd1, 64'sd1);
      chk("rel_level", level, 1);
      chk("rel_out_instr", out_instr, 32'hF8401022);
      out_ready = 1;
      idle(2);

      rnd_rdy = 1;
      for (int i = 0; i < 250; i++) begin
         op = 2'($urandom_range(0, 3));
         send(op, 5'($urandom), 5'($urandom), pick_imm(op));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      rnd_rdy = 0;
      @(posedge clk);
      #1;
      out_ready = 1;
      idle(8);
      chk("drain", q.size(), 0);
      chk("final_rej_count", rej_count, ref_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
